// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic phase timer:
//   - state_t      : run/hold controller states (IDLE, RUN, HOLD)
//   - PH_*         : phase indices of the classic three-phase ring
//   - DEF_*        : default parameter values used by the timer and its compare
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int PH_RED    = 0;
  localparam int PH_GREEN  = 1;
  localparam int PH_YELLOW = 2;

  localparam int DEF_NUM_PHASES = 3;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_PED_PHASE  = 1;
  localparam int DEF_PED_MIN    = 2;

endpackage

// File: rtl/phase_tc_cmp.sv
// phase_tc_cmp
// Combinational terminal-count compare for one phase: tc is high when the
// elapsed count has reached the last cycle of the latched duration.
// A latched duration of 0 behaves like 1, so its last cycle is count 0.
// Ports:
//   i_count  [CNT_W] cycles elapsed in the current phase
//   i_shadow [CNT_W] latched duration of the current phase
//   o_tc     [1]     count is on the last cycle of the phase
module phase_tc_cmp
  import traffic_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] i_count,
  input  logic [CNT_W-1:0] i_shadow,
  output logic             o_tc
);

  logic [CNT_W-1:0] w_last;

  assign w_last = (i_shadow == '0) ? '0 : (i_shadow - CNT_W'(1));
  assign o_tc   = (i_count == w_last);

endmodule

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer
// Traffic-light phase sequencer: walks a fixed ring of NUM_PHASES phases,
// each lasting a programmable number of RUN cycles, under run/hold control.
// Durations are latched into a shadow register on phase entry, so edits to
// i_phase_time only take effect from the next entry of that phase.
// Optional macro TRAFFIC_PED_REQ_EN adds i_ped_req: a sticky pedestrian
// request that cuts PED_PHASE short once PED_MIN cycles have elapsed in it.
// Ports:
//   i_clk          [1]              clock, rising edge
//   i_rst_n        [1]              synchronous active-low reset
//   i_en           [1]              run enable, low returns to IDLE (beats hold)
//   i_hold         [1]              freeze count and phase while high
//   i_phase_time   [NUM_PHASES*CNT_W] packed durations, phase p at [p*CNT_W +: CNT_W]
//   i_ped_req      [1]              pedestrian request (TRAFFIC_PED_REQ_EN only)
//   o_phase_idx    [clog2(NUM_PHASES)] current phase
//   o_phase_onehot [NUM_PHASES]     one-hot of o_phase_idx
//   o_count        [CNT_W]          cycles elapsed in the current phase
//   o_phase_done   [1]              pulse on each phase transition
//   o_wrap         [1]              pulse when the ring returns to phase 0
//   o_busy         [1]              high in RUN or HOLD
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PED_PHASE  = DEF_PED_PHASE,
  parameter int PED_MIN    = DEF_PED_MIN   // must be at least 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic                          i_hold,
  input  logic [NUM_PHASES*CNT_W-1:0]   i_phase_time,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic                          i_ped_req,
`endif
  output logic [$clog2(NUM_PHASES)-1:0] o_phase_idx,
  output logic [NUM_PHASES-1:0]         o_phase_onehot,
  output logic [CNT_W-1:0]              o_count,
  output logic                          o_phase_done,
  output logic                          o_wrap,
  output logic                          o_busy
);

  localparam int                IDX_W        = $clog2(NUM_PHASES);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(NUM_PHASES - 1);
  localparam logic [IDX_W-1:0]  IDX_PED      = IDX_W'(PED_PHASE);
  localparam logic [CNT_W-1:0]  CNT_PED_LAST = CNT_W'(PED_MIN - 1);

  state_t                r_state, w_state_next;
  logic [IDX_W-1:0]      r_phase_idx, w_idx_next, w_idx_inc;
  logic [CNT_W-1:0]      r_count, w_count_next;
  logic [CNT_W-1:0]      r_shadow, w_shadow_next;
  logic [NUM_PHASES-1:0] r_onehot, w_onehot_next;
  logic                  r_phase_done, w_done_next;
  logic                  r_wrap, w_wrap_next;
  logic                  r_busy;
  logic                  w_tc_cmp, w_tc;
  logic                  w_ped_window, w_ped_pending;
  logic [CNT_W-1:0]      w_phase_time [NUM_PHASES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
      assign w_phase_time[gi]  = i_phase_time[gi*CNT_W +: CNT_W];
      assign w_onehot_next[gi] = (w_idx_next == IDX_W'(gi));
    end
  endgenerate

  phase_tc_cmp #(
    .CNT_W (CNT_W)
  ) u_tc_cmp (
    .i_count  (r_count),
    .i_shadow (r_shadow),
    .o_tc     (w_tc_cmp)
  );

  assign w_idx_inc = (r_phase_idx == IDX_LAST) ? '0 : (r_phase_idx + IDX_W'(1));

  // Window in which a pending pedestrian request may end PED_PHASE early.
  assign w_ped_window = (r_state == RUN) && (r_phase_idx == IDX_PED) &&
                        (r_count >= CNT_PED_LAST);

`ifdef TRAFFIC_PED_REQ_EN
  logic r_ped_latch;
  logic w_ped_clear;

  // Leaving PED_PHASE serves the request; dropping to IDLE abandons it.
  // A request arriving on the clearing edge is treated as already served.
  assign w_ped_clear = ((r_phase_idx == IDX_PED) && (w_idx_next != IDX_PED)) ||
                       ((r_state != IDLE) && (w_state_next == IDLE));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)         r_ped_latch <= 1'b0;
    else if (w_ped_clear) r_ped_latch <= 1'b0;
    else if (i_ped_req)   r_ped_latch <= 1'b1;
  end

  assign w_ped_pending = r_ped_latch;
`else
  // No request source in this build; the window term reduces to zero.
  assign w_ped_pending = 1'b0;
`endif

  assign w_tc = w_tc_cmp | (w_ped_window & w_ped_pending);

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_phase_idx;
    w_count_next  = r_count;
    w_shadow_next = r_shadow;
    w_done_next   = 1'b0;
    w_wrap_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_next  = RUN;
          w_idx_next    = IDX_W'(PH_RED);
          w_count_next  = '0;
          w_shadow_next = w_phase_time[PH_RED];
        end
      end
      RUN: begin
        if (!i_en) begin
          w_state_next = IDLE;
          w_idx_next   = IDX_W'(PH_RED);
          w_count_next = '0;
        end else if (i_hold) begin
          // Entering HOLD freezes this cycle too, even on a terminal count.
          w_state_next = HOLD;
        end else if (w_tc) begin
          w_idx_next    = w_idx_inc;
          w_count_next  = '0;
          w_shadow_next = w_phase_time[w_idx_inc];
          w_done_next   = 1'b1;
          w_wrap_next   = (w_idx_inc == '0);
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!i_en) begin
          w_state_next = IDLE;
          w_idx_next   = IDX_W'(PH_RED);
          w_count_next = '0;
        end else if (!i_hold) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = IDX_W'(PH_RED);
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_phase_idx  <= '0;
      r_onehot     <= NUM_PHASES'(1);
      r_count      <= '0;
      r_shadow     <= '0;
      r_phase_done <= 1'b0;
      r_wrap       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_phase_idx  <= w_idx_next;
      r_onehot     <= w_onehot_next;
      r_count      <= w_count_next;
      r_shadow     <= w_shadow_next;
      r_phase_done <= w_done_next;
      r_wrap       <= w_wrap_next;
      r_busy       <= (w_state_next != IDLE);
    end
  end

  assign o_phase_idx    = r_phase_idx;
  assign o_phase_onehot = r_onehot;
  assign o_count        = r_count;
  assign o_phase_done   = r_phase_done;
  assign o_wrap         = r_wrap;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Testbench for traffic_phase_timer (NUM_PHASES=3, CNT_W=4).
// Expected per-cycle output states are queued before each scenario runs and
// popped/compared 1 time unit after every rising clock edge.
module tb_traffic_phase_timer;
  import traffic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        hold;
  logic [11:0] phase_time;
`ifdef TRAFFIC_PED_REQ_EN
  logic        ped_req;
`endif
  wire  [1:0]  phase_idx;
  wire  [2:0]  phase_onehot;
  wire  [3:0]  count;
  wire         phase_done;
  wire         wrap;
  wire         busy;

  // Observed state: {idx, onehot, count, done, wrap, busy}
  wire  [11:0] w_obs = {phase_idx, phase_onehot, count, phase_done, wrap, busy};

  typedef struct {
    int p;
    int c;
    bit done;
    bit wrap;
    bit busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .NUM_PHASES (3),
    .CNT_W      (4),
    .PED_PHASE  (PH_GREEN),
    .PED_MIN    (2)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_hold         (hold),
    .i_phase_time   (phase_time),
`ifdef TRAFFIC_PED_REQ_EN
    .i_ped_req      (ped_req),
`endif
    .o_phase_idx    (phase_idx),
    .o_phase_onehot (phase_onehot),
    .o_count        (count),
    .o_phase_done   (phase_done),
    .o_wrap         (wrap),
    .o_busy         (busy)
  );

  // Queue n RUN-state expectations starting at (p,c,d,w), walking the ring
  // with phase durations t0/t1/t2 (0 counts as 1).
  function automatic void push_walk(int t0, int t1, int t2, int p, int c,
                                    bit d, bit w, int n);
    int t[3];
    t[0] = (t0 == 0) ? 1 : t0;
    t[1] = (t1 == 0) ? 1 : t1;
    t[2] = (t2 == 0) ? 1 : t2;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{p, c, d, w, 1'b1});
      if (c == t[p] - 1) begin
        p = (p + 1) % 3;
        c = 0;
        d = 1'b1;
        w = (p == 0);
      end else begin
        c = c + 1;
        d = 1'b0;
        w = 1'b0;
      end
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    hold  = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
    ped_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [11:0] ev;
    sb.delete();
    rst_n = 1'b0;
    en    = 1'b1;
    hold  = 1'b0;
    phase_time = 12'h235;
    repeat (3) sb.push_back('{0, 0, 1'b0, 1'b0, 1'b0});
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e  = sb.pop_front();
      ev = {2'(e.p), 3'(1 << e.p), 4'(e.c), e.done, e.wrap, e.busy};
      checks++;
      $display("reset k=%0d idx=%0d oh=%b cnt=%0d done=%b wrap=%b busy=%b",
               k, phase_idx, phase_onehot, count, phase_done, wrap, busy);
      if (w_obs !== ev) begin
        errors++;
        $display("FAIL reset k=%0d got %b required %b", k, w_obs, ev);
      end
      if (k == 1) begin
        rst_n = 1'b1;
        en    = 1'b0;
      end
    end
  endtask

  // Plain run: R5 G3 Y2 ring, two full rotations.
  task automatic test_sequence();
    exp_t e;
    logic [11:0] ev;
    sb.delete();
    do_reset();
    phase_time = 12'h235;
    en = 1'b1;
    push_walk(5, 3, 2, 0, 0, 1'b0, 1'b0, 21);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e  = sb.pop_front();
      ev = {2'(e.p), 3'(1 << e.p), 4'(e.c), e.done, e.wrap, e.busy};
      checks++;
      $display("sequence k=%0d idx=%0d oh=%b cnt=%0d done=%b wrap=%b busy=%b",
               k, phase_idx, phase_onehot, count, phase_done, wrap, busy);
      if (w_obs !== ev) begin
        errors++;
        $display("FAIL sequence k=%0d got %b required %b", k, w_obs, ev);
      end
    end
  endtask

  task automatic test_zero_duration();
    exp_t e;
    logic [11:0] ev;
    sb.delete();
    do_reset();
    phase_time = 12'h205;
    en = 1'b1;
    push_walk(5, 0, 2, 0, 0, 1'b0, 1'b0, 12);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e  = sb.pop_front();
      ev = {2'(e.p), 3'(1 << e.p), 4'(e.c), e.done, e.wrap, e.busy};
      checks++;
      $display("zero k=%0d idx=%0d oh=%b cnt=%0d done=%b wrap=%b busy=%b",
               k, phase_idx, phase_onehot, count, phase_done, wrap, busy);
      if (w_obs !== ev) begin
        errors++;
        $display("FAIL zero_dur k=%0d got %b required %b", k, w_obs, ev);
      end
    end
  endtask

  // Largest duration the counter width allows.
  task automatic test_max_duration();
    exp_t e;
    logic [11:0] ev;
    sb.delete();
    do_reset();
    phase_time = 12'h11F;
    en = 1'b1;
    push_walk(15, 1, 1, 0, 0, 1'b0, 1'b0, 19);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e  = sb.pop_front();
      ev = {2'(e.p), 3'(1 << e.p), 4'(e.c), e.done, e.wrap, e.busy};
      checks++;
      $display("maxdur k=%0d idx=%0d oh=%b cnt=%0d done=%b wrap=%b busy=%b",
               k, phase_idx, phase_onehot, count, phase_done, wrap, busy);
      if (w_obs !== ev) begin
        errors++;
        $display("FAIL max_dur k=%0d got %b required %b", k, w_obs, ev);
      end
    end
  endtask

  // hold sampled high on edges 3..6 while RED shows count 2.
  task automatic test_hold();
    exp_t e;
    logic [11:0] ev;
    int hc[10] = '{0, 1, 2, 2, 2, 2, 2, 2, 3, 4};
    sb.delete();
    do_reset();
    phase_time = 12'h235;
    en = 1'b1;
    for (int i = 0; i < 10; i++) sb.push_back('{PH_RED, hc[i], 1'b0, 1'b0, 1'b1});
    sb.push_back('{PH_GREEN, 0, 1'b1, 1'b0, 1'b1});
    sb.push_back('{PH_GREEN, 1, 1'b0, 1'b0, 1'b1});
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e  = sb.pop_front();
      ev = {2'(e.p), 3'(1 << e.p), 4'(e.c), e.done, e.wrap, e.busy};
      checks++;
      $display("hold k=%0d idx=%0d oh=%b cnt=%0d done=%b wrap=%b busy=%b",
               k, phase_idx, phase_onehot, count, phase_done, wrap, busy);
      if (w_obs !== ev) begin
        errors++;
        $display("FAIL hold k=%0d got %b required %b", k, w_obs, ev);
      end
      hold = (k >= 2) && (k <= 5);
    end
  endtask

  // RED duration edited mid-phase: current RED keeps 5, next RED uses 9.
  task automatic test_shadow();
    exp_t e;
    logic [11:0] ev;
    sb.delete();
    do_reset();
    phase_time = 12'h235;
    en = 1'b1;
    push_walk(5, 3, 2, 0, 0, 1'b0, 1'b0, 10);
    push_walk(9, 3, 2, 0, 0, 1'b1, 1'b1, 10);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e  = sb.pop_front();
      ev = {2'(e.p), 3'(1 << e.p), 4'(e.c), e.done, e.wrap, e.busy};
      checks++;
      $display("shadow k=%0d idx=%0d oh=%b cnt=%0d done=%b wrap=%b busy=%b",
               k, phase_idx, phase_onehot, count, phase_done, wrap, busy);
      if (w_obs !== ev) begin
        errors++;
        $display("FAIL shadow k=%0d got %b required %b", k, w_obs, ev);
      end
      if (k == 1) phase_time = 12'h239;
    end
  endtask

  // en dropped (with hold high) at GREEN count 1, restart, then reset mid-YELLOW.
  task automatic test_disable_reset();
    exp_t e;
    logic [11:0] ev;
    sb.delete();
    do_reset();
    phase_time = 12'h235;
    en = 1'b1;
    push_walk(5, 3, 2, 0, 0, 1'b0, 1'b0, 7);
    repeat (2) sb.push_back('{0, 0, 1'b0, 1'b0, 1'b0});
    push_walk(5, 3, 2, 0, 0, 1'b0, 1'b0, 9);
    sb.push_back('{0, 0, 1'b0, 1'b0, 1'b0});
    push_walk(5, 3, 2, 0, 0, 1'b0, 1'b0, 2);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e  = sb.pop_front();
      ev = {2'(e.p), 3'(1 << e.p), 4'(e.c), e.done, e.wrap, e.busy};
      checks++;
      $display("disable k=%0d idx=%0d oh=%b cnt=%0d done=%b wrap=%b busy=%b",
               k, phase_idx, phase_onehot, count, phase_done, wrap, busy);
      if (w_obs !== ev) begin
        errors++;
        $display("FAIL disable_reset k=%0d got %b required %b", k, w_obs, ev);
      end
      case (k)
        6:  begin en = 1'b0; hold = 1'b1; end
        7:  hold = 1'b0;
        8:  en = 1'b1;
        17: rst_n = 1'b0;
        18: rst_n = 1'b1;
        default: ;
      endcase
    end
  endtask

`ifdef TRAFFIC_PED_REQ_EN
  // Request in RED cuts the next GREEN to 2 cycles; a request in YELLOW
  // waits and cuts the following GREEN; the GREEN after that is full length.
  task automatic test_ped_req();
    exp_t e;
    logic [11:0] ev;
    sb.delete();
    do_reset();
    phase_time = 12'h235;
    en = 1'b1;
    push_walk(5, 2, 2, 0, 0, 1'b0, 1'b0, 16);
    push_walk(5, 3, 2, 2, 0, 1'b1, 1'b0, 11);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge clk); #1;
      e  = sb.pop_front();
      ev = {2'(e.p), 3'(1 << e.p), 4'(e.c), e.done, e.wrap, e.busy};
      checks++;
      $display("ped k=%0d idx=%0d oh=%b cnt=%0d done=%b wrap=%b busy=%b",
               k, phase_idx, phase_onehot, count, phase_done, wrap, busy);
      if (w_obs !== ev) begin
        errors++;
        $display("FAIL ped_req k=%0d got %b required %b", k, w_obs, ev);
      end
      ped_req = (k == 2) || (k == 7);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    hold  = 1'b0;
    phase_time = 12'h235;
`ifdef TRAFFIC_PED_REQ_EN
    ped_req = 1'b0;
`endif
    test_reset();
    test_sequence();
    test_zero_duration();
    test_max_duration();
    test_hold();
    test_shadow();
    test_disable_reset();
`ifdef TRAFFIC_PED_REQ_EN
    test_ped_req();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
